exe_mem_skid_buffer: RTL
========================

// Module: exe_mem_skid_buffer
// PURPOSE
//  Sits between the EXE-stage ALU and the MEM stage. Registers the ALU result and
//  the EXE control fields into a 2-entry skid buffer with a valid/ready handshake.
//  Resolves branches from the ALU branch-condition vector and issues a one-cycle
//  PC redirect. The front end predicts not-taken, so every taken branch/jump redirects.
// PARAMETERS
//  XLEN   64  data/PC width
//  BJW     8  branch vector width; bit order BEQ,BNE,BLT,BGE,BLTU,BGEU,JALR,JAL (bit0..7)
//  MCW     8  MEM-stage control field width, passed through opaquely
// PORTS
//  clk            in   1     clock; all state updates on the rising edge
//  rst_n          in   1     synchronous reset, active-low
//  flush          in   1     kill all buffered entries (trap/exception from downstream)
//  ex_valid       in   1     EXE presents an instruction
//  ex_ready       out  1     buffer can accept this cycle
//  ex_pc          in   XLEN  instruction PC
//  ex_alu_out     in   XLEN  ALU result
//  ex_bj_data     in   BJW   ALU branch-condition vector
//  ex_bj_sel      in   BJW   one-hot branch type; all-zero = not a branch/jump
//  ex_target      in   XLEN  branch/jump target address
//  ex_rd          in   5     destination register index
//  ex_rd_wen      in   1     destination write enable
//  ex_mem_ctrl    in   MCW   MEM control bits
//  mem_valid      out  1     head entry valid
//  mem_ready      in   1     MEM consumes the head
//  mem_pc / mem_alu_out / mem_rd / mem_rd_wen / mem_mem_ctrl  out  head-entry fields
//  redirect_valid out  1     one-cycle pulse: fetch must restart at redirect_pc
//  redirect_pc    out  XLEN  redirect target
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): count=0, head ptr=0, all out fields 0, mem_valid=0,
//    redirect_valid=0, redirect_pc=0. Reset takes priority over flush and handshakes.
//  - Storage: 2 entries, circular; count in {0,1,2}. ex_ready = (count!=2), driven
//    from flops only; no combinational path from mem_ready to ex_ready.
//  - push = ex_valid & ex_ready; pop = mem_valid & mem_ready.
//    push&pop in the same cycle: count unchanged, head advances, new entry at tail.
//    count=0 with push: entry visible on mem_* the NEXT cycle (latency 1, no bypass).
//  - mem_valid = (count!=0). mem_* show the head entry and hold stable while
//    mem_valid & ~mem_ready.
//  - Branch resolve on push: taken = |(ex_bj_data & ex_bj_sel).
//    If taken: next cycle redirect_valid=1, redirect_pc=ex_target; otherwise
//    redirect_valid=0. redirect_pc holds its last value when not pulsing.
//  - Two pushes on consecutive cycles, both taken: two consecutive pulses with their
//    own targets (upstream is responsible for squashing the wrong-path instruction).
//  - A taken branch is still buffered and passed to MEM (for the link write).
//  - flush=1: next cycle count=0, mem_valid=0, and any push in the flush cycle is
//    dropped; a redirect from a push in that cycle is suppressed. A redirect pulse
//    already on the outputs completes.
//  - Reset mid-operation: all entries are discarded; no redirect issues after reset.
//  - Unsigned wrap: pointers are 1 bit and wrap 1->0. Count never exceeds 2 or
//    falls below 0 (pop is only possible when mem_valid=1).
// TESTING
//  1 Reset: hold rst_n=0 2 cycles with ex_valid=1 -> mem_valid=0, redirect_valid=0,
//    ex_ready=1 after release.
//  2 Back-to-back: mem_ready=1, push A(alu=0x11) then B(0x22) -> mem_alu_out 0x11 at
//    T+1, 0x22 at T+2, ex_ready stays 1.
//  3 Backpressure: mem_ready=0, push 3 entries -> third stalls (ex_ready=0 after 2);
//    mem_ready=1 then drains 0x11, 0x22, 0x33 in order with no loss or duplication.
//  4 Branch: ex_bj_sel=BEQ, ex_bj_data[BEQ]=1, target=0x8000_0040 -> redirect_valid
//    pulses exactly 1 cycle, redirect_pc=0x8000_0040. With bj_data[BEQ]=0 -> no pulse.
//  5 Flush + push of taken JAL in the same cycle -> no redirect, mem_valid=0 next
//    cycle, count=0.
//  6 Full + simultaneous pop: count=2, mem_ready=1 -> count=1, ex_ready=1 next cycle.

Source files
------------

// File: rtl/exe_mem_skid_buffer.sv
// exe_mem_skid_buffer
//   Two-entry skid buffer between the EXE-stage ALU and the MEM stage.
//   Each accepted instruction has its PC, ALU result, destination info and
//   opaque MEM control bits captured in a circular buffer. The head entry is
//   presented to MEM. Branches and jumps are resolved as they are accepted.
//   The front end always predicts not-taken, so every taken branch/jump
//   produces a one-cycle redirect pulse on the following cycle.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   flush            discard every buffered entry and any push this cycle
//   ex_valid/ready   upstream handshake (ready comes from state only)
//   ex_pc, ex_alu_out, ex_rd, ex_rd_wen, ex_mem_ctrl   fields to buffer
//   ex_bj_data/sel   branch-condition vector and one-hot branch type
//   ex_target        branch/jump target
//   mem_valid/ready  downstream handshake for the head entry
//   mem_*            head-entry fields
//   redirect_valid   one-cycle pulse: fetch restarts at redirect_pc
//   redirect_pc      last redirect target (held between pulses)
module exe_mem_skid_buffer #(
  parameter int XLEN = 64,
  parameter int BJW  = 8,
  parameter int MCW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [BJW-1:0]  ex_bj_data,
  input  logic [BJW-1:0]  ex_bj_sel,
  input  logic [XLEN-1:0] ex_target,
  input  logic [4:0]      ex_rd,
  input  logic            ex_rd_wen,
  input  logic [MCW-1:0]  ex_mem_ctrl,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_pc,
  output logic [XLEN-1:0] mem_alu_out,
  output logic [4:0]      mem_rd,
  output logic            mem_rd_wen,
  output logic [MCW-1:0]  mem_mem_ctrl,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  logic [1:0]      count;
  logic            head;
  logic            tail;
  logic            push;
  logic            pop;
  logic            taken;
  logic            redirect_set;

  logic [XLEN-1:0] buf_pc   [0:1];
  logic [XLEN-1:0] buf_alu  [0:1];
  logic [4:0]      buf_rd   [0:1];
  logic            buf_wen  [0:1];
  logic [MCW-1:0]  buf_ctrl [0:1];

  // Full only when both slots hold an entry; no path from mem_ready.
  assign ex_ready  = (count != 2'd2);
  assign mem_valid = (count != 2'd0);

  // With one entry the free slot is the other one; with zero it is head.
  assign tail = head ^ count[0];

  assign push  = ex_valid & ex_ready;
  assign pop   = mem_valid & mem_ready;
  assign taken = |(ex_bj_data & ex_bj_sel);

  // A push killed by flush must not redirect fetch either.
  assign redirect_set = push & taken & ~flush;

  assign mem_pc       = buf_pc[head];
  assign mem_alu_out  = buf_alu[head];
  assign mem_rd       = buf_rd[head];
  assign mem_rd_wen   = buf_wen[head];
  assign mem_mem_ctrl = buf_ctrl[head];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count          <= 2'd0;
      head           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]   <= '0;
        buf_alu[i]  <= '0;
        buf_rd[i]   <= '0;
        buf_wen[i]  <= 1'b0;
        buf_ctrl[i] <= '0;
      end
    end else begin
      redirect_valid <= redirect_set;
      if (redirect_set) begin
        redirect_pc <= ex_target;
      end

      if (flush) begin
        count <= 2'd0;
      end else begin
        if (push) begin
          buf_pc[tail]   <= ex_pc;
          buf_alu[tail]  <= ex_alu_out;
          buf_rd[tail]   <= ex_rd;
          buf_wen[tail]  <= ex_rd_wen;
          buf_ctrl[tail] <= ex_mem_ctrl;
        end
        if (pop) begin
          head <= ~head;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
